crc16_check_scan: RTL and testbench
===================================

Name: crc16_check_scan

Overview:
- Receive-side counterpart of the crc16_scan generator: consumes a framed stream of 16-bit words whose last word is the transmitted CRC.
- Recomputes CRC-16 over the payload words and compares it with the received CRC word, then reports a pass/fail per frame.
- Sits at the receive end of the CRC link and keeps a saturating error count.
- Running CRC register is on a scan chain (MSB first), so DFT access matches the generator.

Parameters:
- POLY, 16'h1021, CRC-16 generator polynomial (x^16 implicit).
- INIT, 16'h0000, CRC register value at start of each frame.
- MAX_WORDS, 64, maximum payload words per frame before length error.
- ERR_W, 8, width of saturating error counter.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- enable  input  1  word strobe; data_in, sof and eof are sampled when high
- sof  input  1  first word of frame (qualified by enable)
- eof  input  1  this word is the received CRC, i.e. the last word (qualified by enable)
- data_in  input  16  payload word or CRC word
- scan_en  input  1  scan shift mode
- scan_in  input  1  serial scan input
- scan_out  output  1  serial scan output, always equal to crc_reg[15]
- frame_done  output  1  one-cycle pulse, the check result is valid
- crc_ok  output  1  held result: the last frame passed
- crc_err  output  1  held result: the last frame failed (mismatch, length or abort)
- word_cnt  output  7  payload words accepted in the current or last frame
- err_count  output  ERR_W  saturating count of failed frames

Behaviour:
- Reset (synchronous): state=IDLE, crc_reg=INIT, frame_done=0, crc_ok=0, crc_err=0, word_cnt=0, err_count=0. Reset overrides scan_en.
- CRC update is word-parallel, MSB first, non-reflected, no final XOR: crc_next = ((crc_reg ^ data_in) * x^16) mod POLY, i.e. 16 serial shifts in one cycle.
- FSM states: IDLE, ACCUM.
- IDLE, enable&sof&~eof:
  - crc_reg = update(INIT, data_in), word_cnt=1, go to ACCUM.
  - Clear crc_ok/crc_err.
- IDLE, enable&sof&eof: empty payload.
  - Compare data_in with INIT; result is produced next cycle (see Completion).
  - Stay in IDLE; word_cnt=0.
- IDLE, enable&~sof: word ignored, no state change.
- ACCUM, enable&~sof&~eof: crc_reg updated, word_cnt++.
  - If word_cnt would exceed MAX_WORDS: length error, go to IDLE.
- ACCUM, enable&eof&~sof: compare data_in with crc_reg (not updated with the CRC word), go to IDLE.
- ACCUM, enable&sof: abort the current frame and count it as an error (err_count++, crc_err pulse).
  - The new frame starts in the same cycle, using the IDLE rules for sof/eof.
- ACCUM, ~enable: hold.
- Completion (mismatch, length or abort), all registered outputs visible the cycle after the deciding edge:
  - frame_done=1 for exactly one cycle.
  - crc_ok=(match), crc_err=~match.
  - On error, err_count increments and saturates at all-ones.
- crc_reg returns to INIT on every transition to IDLE.
- scan_en=1:
  - crc_reg <= {crc_reg[14:0], scan_in} every cycle.
  - FSM, word_cnt, err_count and result flags hold; enable is ignored; frame_done=0.
  - 16 shifts unload the register MSB first.
- scan_en falling: functional operation resumes from the shifted-in crc_reg. This is intentional, so scan-in can preload state.

Decomposition:
- Package crc16_pkg: CRC_W=16, default POLY/INIT constants, state enum typedef (IDLE, ACCUM), and function crc16_word_next(crc, data, poly).
- One sub-module, crc16_word_update: purely combinational wrapper around the function, shared with the generator side.
- FSM, counters and scan mux stay in crc16_check_scan.

Test Plan:
- Reset, then sof+eof word 16'h0000 (empty payload, INIT=0) -> frame_done pulse next cycle, crc_ok=1, err_count=0.
- Frame: sof word 16'h0001, then eof word 16'h1021 -> crc_ok=1, word_cnt=1; same payload with eof word 16'h1020 -> crc_err=1, err_count=1.
- Frame 16'h0000 (sof), 16'h0001, eof 16'h1021 -> crc_ok=1, word_cnt=2. Repeat with enable gaps between words -> same result.
- sof 16'h0001, then sof 16'h0002 mid-frame (abort), then eof 16'h2042 -> abort pulse with crc_err and err_count=1, then second frame crc_ok=1.
- After sof 16'h0001 (crc_reg=16'h1021), hold scan_en=1 for 16 cycles with scan_in=0 -> scan_out sequence 0,0,0,1,0,0,0,0,0,0,1,0,0,0,0,1, FSM stays ACCUM, no frame_done.
- MAX_WORDS+1 payload words -> length error: crc_err=1 and IDLE. Force 300 failing frames with ERR_W=8 -> err_count saturates at 8'hFF. Assert reset mid-frame -> every output at its reset value on the next cycle.

Source files
------------

// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions for the generator and checker sides of the link.
//   CRC_W            : CRC register width
//   CRC_POLY_DEFAULT : default generator polynomial (x^16 implicit)
//   CRC_INIT_DEFAULT : default register value at the start of a frame
//   crc_state_e      : checker FSM states
//   crc16_word_next  : one 16-bit word through the CRC, MSB first, non-reflected
package crc16_pkg;

   localparam int unsigned CRC_W = 16;
   localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 16'h1021;
   localparam logic [CRC_W-1:0] CRC_INIT_DEFAULT = 16'h0000;

   typedef enum logic {
      StIdle,
      StAccum
   } crc_state_e;

   // ((crc ^ data) * x^16) mod poly: the word is folded into the register and then
   // shifted out 16 times, reducing by the polynomial whenever a one falls off the top.
   function automatic logic [CRC_W-1:0] crc16_word_next(input logic [CRC_W-1:0] crc,
                                                        input logic [CRC_W-1:0] data,
                                                        input logic [CRC_W-1:0] poly);
      logic [CRC_W-1:0] c;
      c = crc ^ data;
      for (int i = 0; i < CRC_W; i++) begin
         if (c[CRC_W-1]) begin
            c = {c[CRC_W-2:0], 1'b0} ^ poly;
         end else begin
            c = {c[CRC_W-2:0], 1'b0};
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/crc16_word_update.sv
// Combinational word-parallel CRC-16 step, shared with the generator.
//   crc_i  : current CRC register value
//   data_i : 16-bit word to absorb
//   crc_o  : CRC after absorbing data_i
module crc16_word_update
   import crc16_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic [CRC_W-1:0] data_i,
   output logic [CRC_W-1:0] crc_o
);

   assign crc_o = crc16_word_next(crc_i, data_i, POLY);

endmodule

// File: rtl/crc16_check_scan.sv
// Receive-side CRC-16 checker. Recomputes the CRC over a framed word stream whose last
// word is the transmitted CRC, reports pass/fail per frame and counts failed frames.
// The running CRC register doubles as a scan chain (MSB first).
//   clk, reset      : clock, synchronous active-high reset
//   enable          : word strobe qualifying sof, eof and data_in
//   sof, eof        : first word of frame / received CRC word
//   data_in         : payload or CRC word
//   scan_en, scan_in: scan shift mode and serial input
//   scan_out        : crc_reg[15]
//   frame_done      : one-cycle pulse when crc_ok / crc_err are updated
//   crc_ok, crc_err : held result of the last frame
//   word_cnt        : payload words in the current or last frame
//   err_count       : saturating count of failed frames
module crc16_check_scan
   import crc16_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY      = CRC_POLY_DEFAULT,
   parameter logic [CRC_W-1:0] INIT      = CRC_INIT_DEFAULT,
   parameter int unsigned      MAX_WORDS = 64,
   parameter int unsigned      ERR_W     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sof,
   input  logic             eof,
   input  logic [15:0]      data_in,
   input  logic             scan_en,
   input  logic             scan_in,
   output logic             scan_out,
   output logic             frame_done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic [6:0]       word_cnt,
   output logic [ERR_W-1:0] err_count
);

   localparam logic [6:0] MaxCnt = 7'(MAX_WORDS);

   crc_state_e       state_q, state_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic             frame_done_q, frame_done_d;
   logic             crc_ok_q, crc_ok_d;
   logic             crc_err_q, crc_err_d;
   logic [6:0]       word_cnt_q, word_cnt_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic [CRC_W-1:0] upd_base, upd_crc;
   logic             len_full;
   logic             complete, pass;

   // A sof word always restarts from INIT, including the abort case in ACCUM.
   assign upd_base = (state_q == StAccum && !sof) ? crc_q : INIT;
   assign len_full = (word_cnt_q >= MaxCnt);

   crc16_word_update #(
      .POLY(POLY)
   ) u_update (
      .crc_i (upd_base),
      .data_i(data_in),
      .crc_o (upd_crc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!scan_en && enable) begin
         unique case (state_q)
            StIdle: begin
               if (sof && !eof) state_d = StAccum;
            end
            StAccum: begin
               if (sof) begin
                  state_d = eof ? StIdle : StAccum;
               end else if (eof || len_full) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      crc_d        = crc_q;
      frame_done_d = 1'b0;
      crc_ok_d     = crc_ok_q;
      crc_err_d    = crc_err_q;
      word_cnt_d   = word_cnt_q;
      err_count_d  = err_count_q;
      complete     = 1'b0;
      pass         = 1'b0;
      if (scan_en) begin
         crc_d = {crc_q[CRC_W-2:0], scan_in};
      end else if (enable) begin
         unique case (state_q)
            StIdle: begin
               if (sof && eof) begin
                  complete   = 1'b1;
                  pass       = (data_in == INIT);
                  word_cnt_d = 7'd0;
                  crc_d      = INIT;
               end else if (sof) begin
                  crc_d      = upd_crc;
                  word_cnt_d = 7'd1;
                  crc_ok_d   = 1'b0;
                  crc_err_d  = 1'b0;
               end
            end
            StAccum: begin
               if (sof) begin
                  // Abort: the old frame fails. A sof+eof word here is dropped with it.
                  complete = 1'b1;
                  if (eof) begin
                     crc_d      = INIT;
                     word_cnt_d = 7'd0;
                  end else begin
                     crc_d      = upd_crc;
                     word_cnt_d = 7'd1;
                  end
               end else if (eof) begin
                  complete = 1'b1;
                  pass     = (data_in == crc_q);
                  crc_d    = INIT;
               end else if (len_full) begin
                  complete = 1'b1;
                  crc_d    = INIT;
               end else begin
                  crc_d      = upd_crc;
                  word_cnt_d = word_cnt_q + 7'd1;
               end
            end
            default: crc_d = INIT;
         endcase
      end
      if (complete) begin
         frame_done_d = 1'b1;
         crc_ok_d     = pass;
         crc_err_d    = !pass;
         if (!pass && !(&err_count_q)) err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         crc_q        <= INIT;
         frame_done_q <= 1'b0;
         crc_ok_q     <= 1'b0;
         crc_err_q    <= 1'b0;
         word_cnt_q   <= 7'd0;
         err_count_q  <= '0;
      end else begin
         crc_q        <= crc_d;
         frame_done_q <= frame_done_d;
         crc_ok_q     <= crc_ok_d;
         crc_err_q    <= crc_err_d;
         word_cnt_q   <= word_cnt_d;
         err_count_q  <= err_count_d;
      end
   end

   assign scan_out   = crc_q[CRC_W-1];
   assign frame_done = frame_done_q;
   assign crc_ok     = crc_ok_q;
   assign crc_err    = crc_err_q;
   assign word_cnt   = word_cnt_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_crc16_check_scan.sv
// Self-checking bench for crc16_check_scan: directed cases plus randomized frames, all
// compared against a frame-level reference model (queue of payload words, bit-serial CRC).
module tb_crc16_check_scan;

   localparam logic [15:0] POLY      = 16'h1021;
   localparam logic [15:0] INIT      = 16'h0000;
   localparam int          MAX_WORDS = 64;
   localparam int          ERR_W     = 8;
   localparam int          ERR_MAX   = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             enable = 1'b0;
   logic             sof = 1'b0;
   logic             eof = 1'b0;
   logic [15:0]      data_in = '0;
   logic             scan_en = 1'b0;
   logic             scan_in = 1'b0;
   logic             scan_out;
   logic             frame_done;
   logic             crc_ok;
   logic             crc_err;
   logic [6:0]       word_cnt;
   logic [ERR_W-1:0] err_count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit          m_in_frame;
   logic [15:0] m_words[$];
   bit          m_done, m_ok, m_err;
   int          m_cnt, m_errcnt;

   always #5 clk = ~clk;

   crc16_check_scan #(
      .POLY     (POLY),
      .INIT     (INIT),
      .MAX_WORDS(MAX_WORDS),
      .ERR_W    (ERR_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .sof       (sof),
      .eof       (eof),
      .data_in   (data_in),
      .scan_en   (scan_en),
      .scan_in   (scan_in),
      .scan_out  (scan_out),
      .frame_done(frame_done),
      .crc_ok    (crc_ok),
      .crc_err   (crc_err),
      .word_cnt  (word_cnt),
      .err_count (err_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Message treated as a bit string, divided by the polynomial one bit at a time.
   function automatic logic [15:0] ref_crc(input logic [15:0] words[$]);
      logic [15:0] c;
      logic        fb;
      c = INIT;
      foreach (words[k]) begin
         for (int b = 15; b >= 0; b--) begin
            fb = c[15] ^ words[k][b];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ POLY;
         end
      end
      return c;
   endfunction

   task automatic model_reset();
      m_in_frame = 0;
      m_words.delete();
      m_done = 0; m_ok = 0; m_err = 0; m_cnt = 0; m_errcnt = 0;
   endtask

   task automatic model_finish(input bit p);
      m_done = 1;
      m_ok   = p;
      m_err  = !p;
      if (!p && m_errcnt < ERR_MAX) m_errcnt++;
   endtask

   task automatic model_step(input bit en, input bit s, input bit e, input logic [15:0] d);
      m_done = 0;
      if (!en) return;
      if (!m_in_frame) begin
         if (s && e) begin
            model_finish(d == INIT);
            m_cnt = 0;
         end else if (s) begin
            m_words.delete();
            m_words.push_back(d);
            m_cnt = 1; m_ok = 0; m_err = 0; m_in_frame = 1;
         end
      end else if (s) begin
         model_finish(0);
         m_words.delete();
         if (e) begin
            m_in_frame = 0; m_cnt = 0;
         end else begin
            m_words.push_back(d); m_cnt = 1;
         end
      end else if (e) begin
         model_finish(d == ref_crc(m_words));
         m_in_frame = 0;
      end else if (m_cnt == MAX_WORDS) begin
         model_finish(0);
         m_in_frame = 0;
      end else begin
         m_words.push_back(d);
         m_cnt++;
      end
   endtask

   task automatic compare_all();
      logic [15:0] c;
      c = m_in_frame ? ref_crc(m_words) : INIT;
      check_eq("frame_done", frame_done, m_done);
      check_eq("crc_ok", crc_ok, m_ok);
      check_eq("crc_err", crc_err, m_err);
      check_eq("word_cnt", word_cnt, m_cnt);
      check_eq("err_count", err_count, m_errcnt);
      check_eq("scan_out", scan_out, c[15]);
   endtask

   task automatic step(input bit en, input bit s, input bit e, input logic [15:0] d);
      enable = en; sof = s; eof = e; data_in = d;
      @(posedge clk); #1;
      model_step(en, s, e, d);
      compare_all();
   endtask

   task automatic do_reset();
      reset = 1; enable = 0; sof = 0; eof = 0; scan_en = 0;
      @(posedge clk); #1;
      model_reset();
      compare_all();
      reset = 0;
   endtask

   task automatic gaps();
      while ($urandom_range(0, 2) == 0) begin
         step(0, 1'($urandom), 1'($urandom), 16'($urandom));
      end
   endtask

   initial begin
      logic [15:0] seq;
      logic [15:0] w;
      logic [15:0] sent[$];
      int          len;
      bit          open_frame;

      model_reset();
      do_reset();
      check_eq("reset_done", frame_done, 0);
      check_eq("reset_errcnt", err_count, 0);

      // Empty payload
      step(1, 1, 1, 16'h0000);
      check_eq("empty_done", frame_done, 1);
      check_eq("empty_ok", crc_ok, 1);
      check_eq("empty_errcnt", err_count, 0);
      step(0, 0, 0, 16'h0000);
      check_eq("done_one_cycle", frame_done, 0);

      // One payload word, good then bad CRC
      step(1, 1, 0, 16'h0001);
      step(1, 0, 1, 16'h1021);
      check_eq("one_word_ok", crc_ok, 1);
      check_eq("one_word_cnt", word_cnt, 1);
      step(1, 1, 0, 16'h0001);
      step(1, 0, 1, 16'h1020);
      check_eq("bad_crc_err", crc_err, 1);
      check_eq("bad_crc_errcnt", err_count, 1);

      // Two words, without and with enable gaps
      step(1, 1, 0, 16'h0000);
      step(1, 0, 0, 16'h0001);
      step(1, 0, 1, 16'h1021);
      check_eq("two_word_ok", crc_ok, 1);
      check_eq("two_word_cnt", word_cnt, 2);
      step(1, 1, 0, 16'h0000);
      step(0, 1, 1, 16'hFFFF);
      step(1, 0, 0, 16'h0001);
      step(0, 0, 1, 16'h5555);
      step(0, 1, 0, 16'hAAAA);
      step(1, 0, 1, 16'h1021);
      check_eq("gap_ok", crc_ok, 1);
      check_eq("gap_cnt", word_cnt, 2);

      // Abort by a mid-frame sof
      do_reset();
      step(1, 1, 0, 16'h0001);
      step(1, 1, 0, 16'h0002);
      check_eq("abort_done", frame_done, 1);
      check_eq("abort_err", crc_err, 1);
      check_eq("abort_errcnt", err_count, 1);
      step(1, 0, 1, 16'h2042);
      check_eq("after_abort_ok", crc_ok, 1);

      // Scan unload of 16'h1021; enable is ignored while shifting
      do_reset();
      step(1, 1, 0, 16'h0001);
      seq = 16'h1021;
      scan_en = 1; scan_in = 0;
      for (int i = 0; i < 16; i++) begin
         check_eq("scan_bit", scan_out, seq[15-i]);
         enable = 1; sof = 1'($urandom); eof = 1'($urandom); data_in = 16'($urandom);
         @(posedge clk); #1;
         check_eq("scan_no_done", frame_done, 0);
         check_eq("scan_cnt_hold", word_cnt, 1);
      end
      scan_en = 0;
      // All-zero register shifted in: equals the CRC of no words.
      m_words.delete();
      step(1, 0, 1, 16'h0000);
      check_eq("scan_preload_ok", crc_ok, 1);

      // Length error on payload word MAX_WORDS+1
      do_reset();
      step(1, 1, 0, 16'($urandom));
      for (int i = 1; i < MAX_WORDS; i++) step(1, 0, 0, 16'($urandom));
      check_eq("len_full_cnt", word_cnt, MAX_WORDS);
      step(1, 0, 0, 16'($urandom));
      check_eq("len_err", crc_err, 1);
      check_eq("len_done", frame_done, 1);
      step(1, 0, 1, 16'h0000);
      check_eq("len_idle", frame_done, 0);

      // Error counter saturation
      do_reset();
      for (int i = 0; i < 300; i++) step(1, 1, 1, 16'h0001);
      check_eq("err_sat", err_count, ERR_MAX);

      // Randomized frames
      do_reset();
      open_frame = 0;
      for (int f = 0; f < 60; f++) begin
         if ($urandom_range(0, 4) == 0 && !open_frame) step(1, 0, 1'($urandom), 16'($urandom));
         len = $urandom_range(0, 5);
         if (open_frame && len == 0) len = 1;
         sent.delete();
         if (len == 0) begin
            w = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : INIT;
            step(1, 1, 1, w);
         end else begin
            for (int k = 0; k < len; k++) begin
               w = 16'($urandom);
               sent.push_back(w);
               gaps();
               step(1, (k == 0), 0, w);
            end
            gaps();
            open_frame = 0;
            case ($urandom_range(0, 7))
               0: open_frame = 1;
               1: begin
                  w = ref_crc(sent) ^ (16'h0001 << $urandom_range(0, 15));
                  step(1, 0, 1, w);
               end
               default: step(1, 0, 1, ref_crc(sent));
            endcase
         end
      end

      // Reset mid-frame, with scan_en asserted to show reset wins
      step(1, 1, 0, 16'h8000);
      step(1, 0, 0, 16'h1234);
      reset = 1; scan_en = 1; scan_in = 1;
      @(posedge clk); #1;
      model_reset();
      check_eq("rst_done", frame_done, 0);
      check_eq("rst_ok", crc_ok, 0);
      check_eq("rst_err", crc_err, 0);
      check_eq("rst_cnt", word_cnt, 0);
      check_eq("rst_errcnt", err_count, 0);
      check_eq("rst_scan_out", scan_out, INIT[15]);
      reset = 0; scan_en = 0; scan_in = 0;
      step(1, 0, 1, 16'h0000);
      check_eq("rst_idle", frame_done, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
